// File: rtl/lat_dual_ram.sv
// Dual-port instruction/data memory model with programmable grant wait states,
// response latency and a per-port limit on granted-but-unanswered requests.
module lat_dual_ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128,
    parameter int GNT_DELAY         = 0,
    parameter int RVALID_DELAY      = 1,
    parameter int MAX_OUTSTANDING   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,

    input  logic                         instr_req_i,
    input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,

    input  logic                         data_req_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_wdata_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic [31:0]                  data_rdata_o
);

    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;
    localparam int NW    = INSTR_RDATA_WIDTH / 32;
    localparam int D     = RVALID_DELAY;
    localparam int IW    = INSTR_RDATA_WIDTH;
    localparam logic [3:0] GD = 4'(GNT_DELAY);
    localparam logic [3:0] MO = 4'(MAX_OUTSTANDING);

    logic [31:0] mem_q [DEPTH];

    logic [3:0]    i_wait_q, i_wait_d, d_wait_q, d_wait_d;
    logic [3:0]    i_outst_q, i_outst_d, d_outst_q, d_outst_d;
    logic          i_gnt, d_gnt;
    logic [D-1:0]  i_vld_q, d_vld_q;
    logic [IW-1:0] i_dat_q [D];
    logic [31:0]   d_dat_q [D];

    logic [WA-1:0] i_base, d_widx;
    logic [IW-1:0] i_rd;
    logic [31:0]   d_rd;
    logic          unused_addr_lsb;

    // Wait count saturates at GNT_DELAY so a stalled request is granted as soon as the stall lifts.
    function automatic logic [3:0] wait_next(input logic req, input logic gnt, input logic [3:0] w);
        if (!req || gnt) begin
            return 4'd0;
        end else if (w == GD) begin
            return w;
        end else begin
            return w + 4'd1;
        end
    endfunction

    assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign i_base = instr_addr_i[ADDR_WIDTH-1:2] & ~WA'(NW - 1);
    assign d_widx = data_addr_i[ADDR_WIDTH-1:2];

    // A response leaving the pipeline this cycle frees its slot for a same-cycle grant.
    assign i_gnt = instr_req_i && !stall_i && !rst_i && (i_wait_q == GD) &&
                   ((i_outst_q - {3'b000, i_vld_q[D-1]}) < MO);
    assign d_gnt = data_req_i && !stall_i && !rst_i && (d_wait_q == GD) &&
                   ((d_outst_q - {3'b000, d_vld_q[D-1]}) < MO);

    always_comb begin
        i_rd = '0;
        for (int w = 0; w < NW; w++) begin
            i_rd[32*w +: 32] = mem_q[i_base | WA'(w)];
        end
        d_rd = data_we_i ? 32'd0 : mem_q[d_widx];
    end

    always_comb begin
        i_wait_d  = wait_next(instr_req_i, i_gnt, i_wait_q);
        d_wait_d  = wait_next(data_req_i, d_gnt, d_wait_q);
        i_outst_d = i_outst_q + {3'b000, i_gnt} - {3'b000, i_vld_q[D-1]};
        d_outst_d = d_outst_q + {3'b000, d_gnt} - {3'b000, d_vld_q[D-1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_wait_q  <= '0;
            d_wait_q  <= '0;
            i_outst_q <= '0;
            d_outst_q <= '0;
            i_vld_q   <= '0;
            d_vld_q   <= '0;
        end else begin
            i_wait_q  <= i_wait_d;
            d_wait_q  <= d_wait_d;
            i_outst_q <= i_outst_d;
            d_outst_q <= d_outst_d;
            i_vld_q[0] <= i_gnt;
            d_vld_q[0] <= d_gnt;
            for (int k = 1; k < D; k++) begin
                i_vld_q[k] <= i_vld_q[k-1];
                d_vld_q[k] <= d_vld_q[k-1];
            end
        end
    end

    // Stages load only behind a valid entry, so the last stage holds rdata while rvalid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < D; k++) begin
                i_dat_q[k] <= '0;
                d_dat_q[k] <= '0;
            end
        end else begin
            if (i_gnt) begin
                i_dat_q[0] <= i_rd;
            end
            if (d_gnt) begin
                d_dat_q[0] <= d_rd;
            end
            for (int k = 1; k < D; k++) begin
                if (i_vld_q[k-1]) begin
                    i_dat_q[k] <= i_dat_q[k-1];
                end
                if (d_vld_q[k-1]) begin
                    d_dat_q[k] <= d_dat_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (d_gnt && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[d_widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign instr_gnt_o    = i_gnt;
    assign instr_rvalid_o = i_vld_q[D-1];
    assign instr_rdata_o  = i_dat_q[D-1];
    assign data_gnt_o     = d_gnt;
    assign data_rvalid_o  = d_vld_q[D-1];
    assign data_rdata_o   = d_dat_q[D-1];

endmodule

// File: tb/tb_lat_dual_ram.sv
// Directed bench for lat_dual_ram: four instances with different timing parameters
// share one stimulus bus; each scenario resets them all and observes one instance.
module tb_lat_dual_ram;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic         ireq = 1'b0;
    logic         dreq = 1'b0;
    logic         dwe = 1'b0;
    logic [21:0]  iaddr = '0;
    logic [21:0]  daddr = '0;
    logic [3:0]   dbe = '0;
    logic [31:0]  dwdata = '0;

    logic         a_igt, a_irv, a_dgt, a_drv;
    logic [127:0] a_ird;
    logic [31:0]  a_drd;
    logic         b_igt, b_irv, b_dgt, b_drv;
    logic [127:0] b_ird;
    logic [31:0]  b_drd;
    logic         c_igt, c_irv, c_dgt, c_drv;
    logic [127:0] c_ird;
    logic [31:0]  c_drd;
    logic         d_igt, d_irv, d_dgt, d_drv;
    logic [127:0] d_ird;
    logic [31:0]  d_drd;

    int           n_cmp = 0;
    int           n_err = 0;
    int           g_cyc [3];
    int           r_cyc [3];
    logic [31:0]  r_dat [3];
    int           maxo;
    int           rv_cnt;

    lat_dual_ram u_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(a_igt),
        .instr_rvalid_o(a_irv), .instr_rdata_o(a_ird),
        .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(a_dgt), .data_rvalid_o(a_drv), .data_rdata_o(a_drd)
    );

    lat_dual_ram #(.ADDR_WIDTH(12), .GNT_DELAY(3), .RVALID_DELAY(2), .MAX_OUTSTANDING(2)) u_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .instr_req_i(ireq), .instr_addr_i(iaddr[11:0]), .instr_gnt_o(b_igt),
        .instr_rvalid_o(b_irv), .instr_rdata_o(b_ird),
        .data_req_i(dreq), .data_addr_i(daddr[11:0]), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(b_dgt), .data_rvalid_o(b_drv), .data_rdata_o(b_drd)
    );

    lat_dual_ram #(.ADDR_WIDTH(12), .GNT_DELAY(0), .RVALID_DELAY(4), .MAX_OUTSTANDING(1)) u_c (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .instr_req_i(ireq), .instr_addr_i(iaddr[11:0]), .instr_gnt_o(c_igt),
        .instr_rvalid_o(c_irv), .instr_rdata_o(c_ird),
        .data_req_i(dreq), .data_addr_i(daddr[11:0]), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(c_dgt), .data_rvalid_o(c_drv), .data_rdata_o(c_drd)
    );

    lat_dual_ram #(.ADDR_WIDTH(12), .GNT_DELAY(0), .RVALID_DELAY(3), .MAX_OUTSTANDING(2)) u_d (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .instr_req_i(ireq), .instr_addr_i(iaddr[11:0]), .instr_gnt_o(d_igt),
        .instr_rvalid_o(d_irv), .instr_rdata_o(d_ird),
        .data_req_i(dreq), .data_addr_i(daddr[11:0]), .data_we_i(dwe), .data_be_i(dbe),
        .data_wdata_i(dwdata), .data_gnt_o(d_dgt), .data_rvalid_o(d_drv), .data_rdata_o(d_drd)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Streams three data reads at 0x40, 0x44, 0x48, advancing the address after each grant.
    task automatic run_stream(input int sel, input int budget);
        int   k;
        int   outst;
        logic g, v;
        logic [31:0] dv;
        k = 0; outst = 0; maxo = 0; rv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            g_cyc[i] = -1; r_cyc[i] = -1; r_dat[i] = '0;
        end
        dreq = 1'b1; dwe = 1'b0; dbe = 4'h0; daddr = 22'h40;
        for (int n = 0; n < budget; n++) begin
            #1;
            case (sel)
                1:       begin g = b_dgt; v = b_drv; dv = b_drd; end
                2:       begin g = c_dgt; v = c_drv; dv = c_drd; end
                default: begin g = d_dgt; v = d_drv; dv = d_drd; end
            endcase
            if (v && rv_cnt < 3) begin
                r_cyc[rv_cnt] = n; r_dat[rv_cnt] = dv; rv_cnt++;
            end
            if (g && k < 3) begin
                g_cyc[k] = n; k++;
            end
            outst = outst + int'(g) - int'(v);
            if (outst > maxo) maxo = outst;
            tick();
            if (k >= 3) dreq = 1'b0;
            else daddr = 22'h40 + 22'(4 * k);
        end
        dreq = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_igt",  128'(a_igt), 128'(0));
        chk("rst_dgt",  128'(a_dgt), 128'(0));
        chk("rst_irv",  128'(a_irv), 128'(0));
        chk("rst_drv",  128'(a_drv), 128'(0));
        chk("rst_ird",  a_ird,       128'(0));
        chk("rst_drd",  128'(a_drd), 128'(0));

        u_a.mem_q[20'h20] = 32'hDEADBEEF;
        rst = 1'b0;
        tick();

        // Single-cycle data read with default timing
        dreq = 1'b1; daddr = 22'h80; dwe = 1'b0;
        #1 chk("rd_gnt", 128'(a_dgt), 128'(1));
        tick();
        dreq = 1'b0;
        #1 chk("rd_rvalid", 128'(a_drv), 128'(1));
        chk("rd_rdata", 128'(a_drd), 128'(32'hDEADBEEF));
        tick();
        #1 chk("hold_rvalid", 128'(a_drv), 128'(0));
        chk("hold_rdata", 128'(a_drd), 128'(32'hDEADBEEF));

        // Stall masks the grant until released
        stall = 1'b1; dreq = 1'b1; daddr = 22'h80;
        #1 chk("stall_gnt", 128'(a_dgt), 128'(0));
        tick();
        stall = 1'b0;
        #1 chk("unstall_gnt", 128'(a_dgt), 128'(1));
        tick();
        dreq = 1'b0;
        #1 chk("unstall_rvalid", 128'(a_drv), 128'(1));
        tick();

        // 128-bit aligned instruction fetch
        u_a.mem_q[20'h20] = 32'd1; u_a.mem_q[20'h21] = 32'd2;
        u_a.mem_q[20'h22] = 32'd3; u_a.mem_q[20'h23] = 32'd4;
        ireq = 1'b1; iaddr = 22'h84;
        #1 chk("if_gnt", 128'(a_igt), 128'(1));
        tick();
        ireq = 1'b0;
        #1 chk("if_rvalid", 128'(a_irv), 128'(1));
        chk("if_rdata", a_ird, 128'h00000004_00000003_00000002_00000001);
        tick();

        // Byte-enabled write with a same-edge instruction read of the same word
        for (int w = 0; w < 4; w++) u_a.mem_q[20'h40 + 20'(w)] = 32'd0;
        ireq = 1'b1; iaddr = 22'h100;
        dreq = 1'b1; daddr = 22'h100; dwe = 1'b1; dbe = 4'b0101; dwdata = 32'hAABBCCDD;
        #1 chk("wr_igt", 128'(a_igt), 128'(1));
        chk("wr_dgt", 128'(a_dgt), 128'(1));
        tick();
        ireq = 1'b0; dwe = 1'b0; dbe = 4'h0;
        #1 chk("wr_if_rvalid", 128'(a_irv), 128'(1));
        chk("wr_if_old", a_ird, 128'(0));
        chk("wr_rsp_rvalid", 128'(a_drv), 128'(1));
        chk("wr_rsp_rdata", 128'(a_drd), 128'(0));
        chk("rd_after_wr_gnt", 128'(a_dgt), 128'(1));
        tick();
        dreq = 1'b0;
        #1 chk("rd_after_wr", 128'(a_drd), 128'(32'h00BB00DD));

        // Write with no byte enables still responds but leaves storage alone
        tick();
        dreq = 1'b1; dwe = 1'b1; dbe = 4'h0; dwdata = 32'hFFFFFFFF;
        tick();
        dwe = 1'b0;
        #1 chk("be0_rvalid", 128'(a_drv), 128'(1));
        tick();
        dreq = 1'b0;
        #1 chk("be0_readback", 128'(a_drd), 128'(32'h00BB00DD));

        // Wait states and latency
        pulse_reset();
        u_b.mem_q[10'h10] = 32'h11; u_b.mem_q[10'h11] = 32'h22; u_b.mem_q[10'h12] = 32'h33;
        run_stream(1, 18);
        chk("gd_gnt0", 128'(g_cyc[0]), 128'(3));
        chk("gd_gnt1", 128'(g_cyc[1]), 128'(7));
        chk("gd_gnt2", 128'(g_cyc[2]), 128'(11));
        chk("gd_rv0", 128'(r_cyc[0]), 128'(5));
        chk("gd_rv1", 128'(r_cyc[1]), 128'(9));
        chk("gd_rv2", 128'(r_cyc[2]), 128'(13));
        chk("gd_dat0", 128'(r_dat[0]), 128'(32'h11));
        chk("gd_dat1", 128'(r_dat[1]), 128'(32'h22));
        chk("gd_dat2", 128'(r_dat[2]), 128'(32'h33));

        // Outstanding limit of one with four-cycle response latency
        pulse_reset();
        u_c.mem_q[10'h10] = 32'h44; u_c.mem_q[10'h11] = 32'h55; u_c.mem_q[10'h12] = 32'h66;
        run_stream(2, 16);
        chk("mo_gnt0", 128'(g_cyc[0]), 128'(0));
        chk("mo_gnt1", 128'(g_cyc[1]), 128'(4));
        chk("mo_gnt2", 128'(g_cyc[2]), 128'(8));
        chk("mo_rv2", 128'(r_cyc[2]), 128'(12));
        chk("mo_dat1", 128'(r_dat[1]), 128'(32'h55));
        chk("mo_max_outst", 128'(maxo), 128'(1));

        // Reset with two responses in flight, plus a write attempted during reset
        pulse_reset();
        u_d.mem_q[10'h10] = 32'h77; u_d.mem_q[10'h11] = 32'h88;
        dreq = 1'b1; daddr = 22'h40; dwe = 1'b0;
        #1 chk("rf_gnt0", 128'(d_dgt), 128'(1));
        tick();
        daddr = 22'h44;
        #1 chk("rf_gnt1", 128'(d_dgt), 128'(1));
        tick();
        dreq = 1'b0;
        rst = 1'b1;
        #1 chk("rf_rvalid_rst", 128'(d_drv), 128'(0));
        dreq = 1'b1; dwe = 1'b1; dbe = 4'hF; dwdata = 32'hFFFFFFFF; daddr = 22'h40;
        #1 chk("rf_gnt_rst", 128'(d_dgt), 128'(0));
        tick();
        tick();
        dreq = 1'b0; dwe = 1'b0; dbe = 4'h0;
        rst = 1'b0;
        rv_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (d_drv) rv_cnt++;
            tick();
        end
        chk("rf_no_rvalid", 128'(rv_cnt), 128'(0));
        chk("rf_drdata", 128'(d_drd), 128'(0));
        chk("rf_irdata", d_ird, 128'(0));
        chk("rf_mem0", 128'(u_d.mem_q[10'h10]), 128'(32'h77));
        chk("rf_mem1", 128'(u_d.mem_q[10'h11]), 128'(32'h88));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lat_dual_ram.md
# lat_dual_ram

Dual-port instruction/data memory model with parametrised fetch width, grant wait states, response latency and outstanding-request limit. Replaces the fixed single-cycle memory behind the core in the Verilator top so the core's req/gnt/rvalid handling can be exercised under realistic memory timing. Both ports share one word-organised storage array. Each port runs an independent grant counter and response pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 22: byte-address width of both ports; storage is 2^(ADDR_WIDTH-2) 32-bit words.
- INSTR_RDATA_WIDTH, 128: instruction read width; multiple of 32, power of two, from 32 to 128.
- GNT_DELAY, 0: wait-state cycles from first request cycle to grant, 0..15.
- RVALID_DELAY, 1: cycles from grant edge to rvalid, 1..8.
- MAX_OUTSTANDING, 2: granted-but-unanswered limit per port, 1..8.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- stall_i, in, 1: bench stall; while high, both gnt outputs are forced low.
- instr_req_i, in, 1: instruction read request.
- instr_addr_i, in, ADDR_WIDTH: byte address; low log2(INSTR_RDATA_WIDTH/8) bits ignored.
- instr_gnt_o, out, 1: request accepted this cycle.
- instr_rvalid_o, out, 1: instr_rdata_o valid.
- instr_rdata_o, out, INSTR_RDATA_WIDTH: aligned block; lowest-address word in bits [31:0].
- data_req_i, in, 1: data request.
- data_addr_i, in, ADDR_WIDTH: byte address; bits [1:0] ignored.
- data_we_i, in, 1: 1 = write.
- data_be_i, in, 4: byte enables; bit n covers byte lane [8n+7:8n].
- data_wdata_i, in, 32: write data.
- data_gnt_o, out, 1: request accepted this cycle.
- data_rvalid_o, out, 1: response valid; issued for reads and writes.
- data_rdata_o, out, 32: read data; 0 for a write response.

## Operation
- Handshake per port: a transfer happens in a cycle with req && gnt. The requester holds req, addr, we, be and wdata stable until gnt. Dropping req before gnt is a protocol violation; behaviour is undefined but must not hang.
- Grant counter per port: counts consecutive cycles with req high and gnt low. It clears on grant, on req low, and on reset.
- gnt = req && !stall_i && (outstanding < MAX_OUTSTANDING) && (wait count == GNT_DELAY). With GNT_DELAY=0 the grant is combinational in the request cycle.
- Outstanding counter per port increments on grant and decrements on rvalid. When both happen in the same cycle it is unchanged.
- Reads sample the storage at the grant edge. The result enters a RVALID_DELAY-stage valid/data shift pipeline.
- Writes commit the enabled bytes at the grant edge and push a response with data 0. A write with be=0 changes no storage but still produces a response.
- Same-edge instruction read and data write to the same word: the instruction read returns the old data. A data read granted one cycle after a write returns the new data.
- rdata holds its last value while rvalid is low.
- Reset clears grant counters, outstanding counters and pipelines. Storage contents are retained; the bench preloads them via hierarchical access.

## Timing
- Reset values: instr_gnt_o=0, data_gnt_o=0, instr_rvalid_o=0, data_rvalid_o=0, instr_rdata_o=0, data_rdata_o=0.
- Latency from the first request cycle to rvalid is GNT_DELAY + RVALID_DELAY cycles when not throttled.
- Throughput: one grant per cycle per port when GNT_DELAY=0 and MAX_OUTSTANDING >= RVALID_DELAY. Otherwise gnt is throttled.
- Responses return strictly in grant order, one per cycle at most.
- rst_i asserted mid-transfer drops all in-flight responses immediately; no rvalid appears after reset release for pre-reset grants. A write granted on the same edge as reset assertion is not committed.
- stall_i does not freeze the grant counter or the response pipeline. It only masks gnt, and the wait count saturates at GNT_DELAY.

## Test plan
- Defaults, storage word 0x20 = 0xDEADBEEF, data read at 0x80 → gnt in the request cycle, rvalid next cycle with 0xDEADBEEF.
- Instruction fetch at 0x84 with words 0x20..0x23 = 1,2,3,4 → instr_rdata_o = 0x00000004_00000003_00000002_00000001.
- GNT_DELAY=3, RVALID_DELAY=2, continuous data reads → first gnt 3 cycles after req, rvalid 2 cycles after each gnt, in order.
- MAX_OUTSTANDING=1, RVALID_DELAY=4, back-to-back requests → grants spaced 4 cycles apart; outstanding never exceeds 1.
- Write 0xAABBCCDD with be=4'b0101 to a word holding 0 → word reads back 0x00BB00DD; write response rdata = 0. Same-edge instr read of that word returns 0.
- Assert rst_i with 2 responses in flight, then release → no rvalid for 10 cycles; outputs are 0; storage is unchanged.
